// File: rtl/uart_rx_data40.sv
// uart_rx_data40: packs five byte strobes into one 40-bit word, LSB first,
//   and drops a partial frame when the gap between its bytes is too long.
// Latency: Rx_Done one cycle after the 5th strobe; Frame_Err TIMEOUT_CYCLES
//   cycles after the last accepted strobe. No backpressure: every strobe is taken.
// Ports: Clk, Reset_n (async active-low), Byte_Data/Byte_Done (byte stream in),
//   Data40/Rx_Done (word out), Frame_Err (timeout pulse), Busy (frame in progress).
module uart_rx_data40 #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [7:0]  Byte_Data,
  input  logic        Byte_Done,
  output logic [39:0] Data40,
  output logic        Rx_Done,
  output logic        Frame_Err,
  output logic        Busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t        state;
  logic [39:0]   asm_buf;
  logic [2:0]    idx;
  logic [TW-1:0] tmr;
  logic [TW-1:0] tmr_inc;

  // The expiry test looks at the incremented count, so the pulse lands exactly
  // TIMEOUT_CYCLES cycles after the last strobe and a strobe in the final idle
  // cycle still counts as part of the frame.
  assign tmr_inc = tmr + TW'(1);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      asm_buf   <= '0;
      idx       <= '0;
      tmr       <= '0;
      Data40    <= '0;
      Rx_Done   <= 1'b0;
      Frame_Err <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      Rx_Done   <= 1'b0;
      Frame_Err <= 1'b0;
      case (state)
        IDLE: begin
          if (Byte_Done) begin
            asm_buf[7:0] <= Byte_Data;
            idx          <= 3'd1;
            tmr          <= '0;
            state        <= COLLECT;
            Busy         <= 1'b1;
          end
        end
        COLLECT: begin
          if (Byte_Done) begin
            // A byte always wins over a coincident timer expiry.
            asm_buf[{idx, 3'b000} +: 8] <= Byte_Data;
            tmr <= '0;
            if (idx == 3'd4) begin
              Data40  <= {Byte_Data, asm_buf[31:0]};
              Rx_Done <= 1'b1;
              idx     <= '0;
              state   <= IDLE;
              Busy    <= 1'b0;
            end else begin
              idx <= idx + 3'd1;
            end
          end else if (tmr_inc == TMR_LAST) begin
            Frame_Err <= 1'b1;
            idx       <= '0;
            tmr       <= '0;
            state     <= IDLE;
            Busy      <= 1'b0;
          end else begin
            tmr <= tmr_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_data40.sv
// tb_uart_rx_data40: directed bench for uart_rx_data40.
// One instance with TIMEOUT_CYCLES=50 for the timing cases, one with the
// default timeout for the slow-baud normal frame.
module tb_uart_rx_data40;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_done = 1'b0;
  logic [39:0] data40;
  logic        rx_done, frame_err, busy;

  logic [7:0]  s_byte_data = '0;
  logic        s_byte_done = 1'b0;
  logic [39:0] s_data40;
  logic        s_rx_done, s_frame_err, s_busy;

  int total = 0;
  int bad = 0;
  int rx_cnt = 0, fe_cnt = 0, both_cnt = 0;
  int s_rx_cnt = 0, s_fe_cnt = 0;

  always #5 Clk = ~Clk;

  uart_rx_data40 #(.TIMEOUT_CYCLES(50)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Byte_Data(byte_data), .Byte_Done(byte_done),
    .Data40(data40), .Rx_Done(rx_done), .Frame_Err(frame_err), .Busy(busy)
  );

  uart_rx_data40 dut_slow (
    .Clk(Clk), .Reset_n(Reset_n), .Byte_Data(s_byte_data), .Byte_Done(s_byte_done),
    .Data40(s_data40), .Rx_Done(s_rx_done), .Frame_Err(s_frame_err), .Busy(s_busy)
  );

  // Pulse counters, sampled mid-cycle.
  always @(negedge Clk) begin
    if (rx_done) rx_cnt++;
    if (frame_err) fe_cnt++;
    if (rx_done && frame_err) both_cnt++;
    if (s_rx_done) s_rx_cnt++;
    if (s_frame_err) s_fe_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Strobe one byte in the current cycle; returns in the following cycle.
  task automatic strobe(input logic [7:0] b);
    byte_data = b;
    byte_done = 1'b1;
    cyc(1);
    byte_done = 1'b0;
  endtask

  task automatic s_strobe(input logic [7:0] b);
    s_byte_data = b;
    s_byte_done = 1'b1;
    cyc(1);
    s_byte_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rx0, fe0;
    // Reset state
    #3;
    chk("rst_data40", data40, 40'h0);
    chk("rst_rx_done", rx_done, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    cyc(2);
    Reset_n = 1'b1;
    cyc(2);

    // Back-to-back: 10 strobes on consecutive cycles
    byte_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      byte_data = 8'(i);
      cyc(1);
      if (i == 0) chk("b2b_busy_after1", busy, 1'b1);
      if (i == 4) begin
        chk("b2b_rx1", rx_done, 1'b1);
        chk("b2b_word1", data40, 40'h0403020100);
        chk("b2b_busy_done", busy, 1'b0);
      end
      if (i == 5) chk("b2b_rx_gap", rx_done, 1'b0);
      if (i == 9) begin
        chk("b2b_rx2", rx_done, 1'b1);
        chk("b2b_word2", data40, 40'h0908070605);
      end
    end
    byte_done = 1'b0;
    cyc(1);
    chk("b2b_rx_cnt", rx_cnt, 2);

    // Timeout: 3 bytes then silence
    fe0 = fe_cnt;
    strobe(8'hAA);
    strobe(8'hBB);
    strobe(8'hCC);   // now 1 cycle after the 0xCC strobe
    cyc(48);         // 49 cycles after
    chk("to_no_err_49", frame_err, 1'b0);
    chk("to_busy_49", busy, 1'b1);
    cyc(1);          // 50 cycles after
    chk("to_err_50", frame_err, 1'b1);
    chk("to_busy_fall", busy, 1'b0);
    chk("to_data_kept", data40, 40'h0908070605);
    cyc(1);
    chk("to_err_one_cycle", frame_err, 1'b0);
    chk("to_fe_cnt", fe_cnt - fe0, 1);
    for (int i = 1; i <= 5; i++) strobe(8'(i));
    chk("to_next_rx", rx_done, 1'b1);
    chk("to_next_word", data40, 40'h0504030201);

    // Boundary: 4th byte in the last idle cycle before expiry
    fe0 = fe_cnt;
    cyc(3);
    strobe(8'h10);
    strobe(8'h11);
    strobe(8'h12);   // 1 cycle after 3rd strobe
    cyc(48);         // cycle 49 after the 3rd strobe
    strobe(8'h13);
    strobe(8'h14);
    chk("bnd49_rx", rx_done, 1'b1);
    chk("bnd49_word", data40, 40'h1413121110);
    chk("bnd49_no_err", fe_cnt - fe0, 0);

    // Boundary: strobe at cycle 50 lands on Frame_Err and begins a new frame
    cyc(2);
    strobe(8'h21);
    strobe(8'h22);
    strobe(8'h23);
    cyc(49);         // cycle 50 after the 3rd strobe
    chk("bnd50_err", frame_err, 1'b1);
    strobe(8'h31);
    chk("bnd50_busy_new", busy, 1'b1);
    for (int i = 2; i <= 5; i++) strobe(8'h30 + 8'(i));
    chk("bnd50_rx", rx_done, 1'b1);
    chk("bnd50_word", data40, 40'h3534333231);
    chk("bnd50_fe_cnt", fe_cnt - fe0, 1);

    // Reset mid-frame
    cyc(2);
    rx0 = rx_cnt;
    fe0 = fe_cnt;
    strobe(8'hE0);
    strobe(8'hE1);
    Reset_n = 1'b0;
    #1;
    chk("mrst_data40", data40, 40'h0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_rx", rx_done, 1'b0);
    chk("mrst_err", frame_err, 1'b0);
    cyc(2);
    Reset_n = 1'b1;
    cyc(60);
    chk("mrst_no_pulses", (rx_cnt - rx0) + (fe_cnt - fe0), 0);
    chk("mrst_data_still0", data40, 40'h0);
    for (int i = 0; i < 5; i++) strobe(8'hF0 + 8'(i));
    chk("mrst_rx", rx_done, 1'b1);
    chk("mrst_word", data40, 40'hF4F3F2F1F0);

    // Restart on the Rx_Done cycle
    strobe(8'h77);
    chk("rs_busy", busy, 1'b1);
    for (int i = 0; i < 4; i++) strobe(8'h78 + 8'(i));
    chk("rs_rx", rx_done, 1'b1);
    chk("rs_word", data40, 40'h7B7A797877);
    cyc(1);
    chk("rs_rx_one_cycle", rx_done, 1'b0);

    // Normal frame on the default-timeout instance, strobes 4340 cycles apart
    s_strobe(8'h11);
    for (int i = 2; i <= 5; i++) begin
      cyc(4339);
      chk("nrm_busy", s_busy, 1'b1);
      s_strobe(8'(8'h11 * i));
    end
    chk("nrm_rx", s_rx_done, 1'b1);
    chk("nrm_word", s_data40, 40'h5544332211);
    chk("nrm_busy_end", s_busy, 1'b0);
    cyc(1);
    chk("nrm_rx_cnt", s_rx_cnt, 1);
    chk("nrm_fe_cnt", s_fe_cnt, 0);
    chk("both_never", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_data40.md
# uart_rx_data40

Receive-side counterpart of the 40-bit UART transmit path. Consumes the byte strobe stream of the UART byte receiver and packs five consecutive bytes into one 40-bit word, least-significant byte first, matching the transmit order `Data40[7:0]` to `Data40[39:32]`. An inter-byte timeout discards partial frames so a lost byte cannot misalign later frames. It sits between the byte receiver and the application logic that consumes 40-bit words.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 100000: idle Clk cycles allowed between bytes of one frame before the partial frame is dropped. Legal range is 2 to 2^24-1.

Ports:
- `Clk`, input, 1: system clock. All logic is on the rising edge.
- `Reset_n`, input, 1: asynchronous, active-low reset.
- `Byte_Data`, input, 8: received byte. Valid only in cycles where `Byte_Done`=1.
- `Byte_Done`, input, 1: byte strobe from the byte receiver. Every high cycle counts as one byte.
- `Data40`, output, 40: last complete word. Held until the next complete frame.
- `Rx_Done`, output, 1: one-cycle pulse; `Data40` is new in that cycle.
- `Frame_Err`, output, 1: one-cycle pulse when a partial frame is discarded by timeout.
- `Busy`, output, 1: high while a partial frame is being collected.

## Operation
- Internal state:
  - 40-bit assembly register `buf`.
  - 3-bit byte index `idx` (0 to 4).
  - Timer `tmr`, width `$clog2(TIMEOUT_CYCLES)`.
  - States IDLE and COLLECT.
- IDLE:
  - `Busy`=0.
  - On `Byte_Done`: `buf[7:0]` <= `Byte_Data`, `idx` <= 1, `tmr` <= 0, go to COLLECT.
- COLLECT, cycle with `Byte_Done`=1 and `idx`=k (k from 1 to 4):
  - `buf[8k+7:8k]` <= `Byte_Data`, `tmr` <= 0.
  - If k<4: `idx` <= k+1.
  - If k=4: `Data40` <= {`Byte_Data`, `buf[31:0]`}, `Rx_Done` <= 1, `idx` <= 0, go to IDLE.
- COLLECT, cycle with `Byte_Done`=0:
  - `tmr` increments.
  - If `tmr` = `TIMEOUT_CYCLES`-1: `Frame_Err` <= 1, `idx` <= 0, go to IDLE. `buf` contents are don't-care; `Data40` is unchanged.
- Simultaneous `Byte_Done` and timer expiry: the byte wins. It is accepted, the timer clears, and there is no `Frame_Err`.
- Back-to-back strobes (`Byte_Done` high on consecutive cycles) are each accepted as separate bytes. The upstream side guarantees one strobe per byte.
- `Rx_Done` and `Frame_Err` are never high in the same cycle.
- A `Byte_Done` in the cycle `Rx_Done` or `Frame_Err` is high is accepted normally as byte 0 of a new frame.
- No other path changes `Data40`: it changes only on `Rx_Done`.

## Timing
- Reset values: `Data40`=0, `Rx_Done`=0, `Frame_Err`=0, `Busy`=0, state IDLE, `idx`=0, `tmr`=0, `buf`=0.
- Reset asserted mid-frame: the partial frame is dropped immediately, no pulse is emitted, and `Data40` returns to 0.
- `Rx_Done` latency: high exactly in the cycle after the 5th `Byte_Done` strobe, for one cycle. `Data40` is valid from that same cycle.
- `Busy`: high from the cycle after the 1st strobe through the cycle of the 5th strobe (registered).
- `Frame_Err` latency: high exactly `TIMEOUT_CYCLES` cycles after the last accepted strobe of the partial frame, for one cycle.
- Minimum frame duration is 5 cycles. There is no throughput limit beyond one byte per cycle.

## Test plan
- **Normal frame:** bytes 0x11, 0x22, 0x33, 0x44, 0x55, strobes 4340 cycles apart -> `Data40`=0x5544332211, single `Rx_Done` one cycle after the 5th strobe, `Frame_Err` never high.
- **Timeout:** `TIMEOUT_CYCLES`=50; bytes 0xAA, 0xBB, 0xCC, then silence -> `Frame_Err` pulse 50 cycles after the 0xCC strobe, `Data40` keeps its prior value, `Busy` falls. A following frame 0x01 to 0x05 -> `Data40`=0x0504030201.
- **Boundary:** `TIMEOUT_CYCLES`=50; 4th byte strobed exactly at cycle 49 after the 3rd -> no `Frame_Err`. Completing the frame yields the correct word. Strobe at cycle 50 -> `Frame_Err`, and that byte starts a new frame as byte 0.
- **Back-to-back:** 10 strobes on consecutive cycles, bytes 0x00 to 0x09 -> two `Rx_Done` pulses 5 cycles apart, words 0x0403020100 then 0x0908070605.
- **Reset mid-frame:** assert `Reset_n`=0 after 2 bytes, release, send 5 bytes 0xF0 to 0xF4 -> all outputs 0 during reset, no stray pulses, `Data40`=0xF4F3F2F1F0.
- **Restart on done cycle:** strobe byte 0x77 in the `Rx_Done` cycle, then 4 more bytes 0x78 to 0x7B -> next word 0x7B7A797877.
